// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the PC, sequences IDLE/RUN/FLUSH/HALTED and counts accepted fetches.
// Optional build macro PC_ALIGN_CHECK_EN forces word-aligned redirect targets and raises a sticky flag.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned COUNT_W  = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        pc_plus4_i,
    input  logic               redirect_i,
    input  logic [31:0]        redirect_pc_i,
    input  logic               stall_i,
    input  logic               halt_i,
    input  logic               fetch_ready_i,
    output logic [31:0]        pc_o,
    output logic               fetch_valid_o,
    output logic [COUNT_W-1:0] fetch_count_o,
    output logic [1:0]         state_o,
    output logic               misalign_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               misalign_q, misalign_d;

    logic        accept;
    logic        take_redirect;
    logic        count_bump;
    logic [31:0] target_pc;
    logic        target_misaligned;

`ifdef PC_ALIGN_CHECK_EN
    assign target_pc         = {redirect_pc_i[31:2], 2'b00};
    assign target_misaligned = |redirect_pc_i[1:0];
`else
    assign target_pc         = redirect_pc_i;
    assign target_misaligned = 1'b0;
`endif

    assign fetch_valid_o = (state_q == ST_RUN);
    assign accept        = fetch_valid_o & fetch_ready_i & ~stall_i;
    // IDLE is an unconditional one-cycle start bubble, so a redirect there is ignored.
    assign take_redirect = redirect_i & (state_q != ST_IDLE);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q;
        misalign_d = misalign_q;
        count_bump = 1'b0;

        if (take_redirect) begin
            pc_d       = target_pc;
            state_d    = ST_FLUSH;
            misalign_d = misalign_q | target_misaligned;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN: begin
                    // A halt still lets a same-cycle accepted fetch retire.
                    if (accept) begin
                        pc_d       = pc_plus4_i;
                        count_bump = 1'b1;
                    end
                    if (halt_i) state_d = ST_HALTED;
                end
                ST_FLUSH:  state_d = halt_i ? ST_HALTED : ST_RUN;
                ST_HALTED: state_d = ST_HALTED;
                default:   state_d = ST_IDLE;
            endcase
        end

        if (count_bump && (count_q != '1)) count_d = count_q + COUNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_o          = pc_q;
    assign fetch_count_o = count_q;
    assign state_o       = state_q;
    assign misalign_o    = misalign_q;

endmodule
